// File: rtl/cache_pkg.sv
// Constants and state encoding shared by the cache refill sequencer and the miss FSM.
package cache_pkg;

  localparam int CACHE_ADDR_W        = 32;
  localparam int CACHE_DATA_W        = 32;
  localparam int CACHE_WORDS_PER_BLK = 4;
  localparam int CACHE_TIMEOUT       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } refill_state_e;

  // A timeout of 0 still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/refill_timer.sv
// Per-word ack wait counter: clear/enable up-counter that saturates and flags expiry.
module refill_timer
  import cache_pkg::*;
#(
  parameter int TIMEOUT = CACHE_TIMEOUT,
  parameter int CNT_W   = cnt_width(TIMEOUT)
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // TIMEOUT of zero disables expiry entirely.
  assign expired = (TIMEOUT != 0) && (count_q == CNT_LAST);

endmodule

// File: rtl/cache_refill_seq.sv
// Block refill sequencer: fetches one cache block word-by-word over req/ack and
// writes each word into the data array, pulsing end_fill when the block is complete.
module cache_refill_seq
  import cache_pkg::*;
#(
  parameter int ADDR_W        = CACHE_ADDR_W,
  parameter int DATA_W        = CACHE_DATA_W,
  parameter int WORDS_PER_BLK = CACHE_WORDS_PER_BLK,
  parameter int TIMEOUT       = CACHE_TIMEOUT,
  parameter int IDX_W         = $clog2(WORDS_PER_BLK)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] blk_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              dwr,
  output logic [IDX_W-1:0]  dword_idx,
  output logic [DATA_W-1:0] dwdata,
  output logic              end_fill,
  output logic              busy,
  output logic              err
);

  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(WORDS_PER_BLK - 1);
  localparam logic [ADDR_W-1:0] IDX_MASK = ADDR_W'(WORDS_PER_BLK - 1);

  refill_state_e     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  refill_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    err_d       = 1'b0;
    timer_clear = 1'b0;
    timer_en    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_clear = 1'b1;
        // abort outranks a simultaneous start so the miss FSM can cancel cleanly.
        if (start && !abort) begin
          base_d  = blk_addr & ~IDX_MASK;
          idx_d   = '0;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (mem_ack) begin
          wdata_d = mem_rdata;
          state_d = ST_WRITE;
        end else if (timer_expired) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          timer_en = 1'b1;
        end
      end

      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (idx_q == IDX_LAST) begin
          state_d = ST_DONE;
        end else begin
          idx_d       = idx_q + 1'b1;
          timer_clear = 1'b1;
          state_d     = ST_REQ;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      base_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode only registered state, so nothing combinational reaches them from inputs.
  always_comb begin
    mem_req   = (state_q == ST_REQ);
    mem_addr  = mem_req ? (base_q | {{(ADDR_W-IDX_W){1'b0}}, idx_q}) : '0;
    dwr       = (state_q == ST_WRITE);
    dword_idx = dwr ? idx_q : '0;
    dwdata    = dwr ? wdata_q : '0;
    end_fill  = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    err       = err_q;
  end

endmodule

// File: tb/tb_cache_refill_seq.sv
// Scoreboard bench for cache_refill_seq: stimulus pushes expected traffic, a
// negedge monitor pops and compares whenever the DUT presents an ack, write or pulse.
module tb_cache_refill_seq;

  localparam int EVT_END = 1;
  localparam int EVT_ERR = 2;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int code;
    int lat;
  } evt_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        abort;
  logic [31:0] blk_addr;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        dwr;
  logic [1:0]  dword_idx;
  logic [31:0] dwdata;
  logic        end_fill;
  logic        busy;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ack_delay = 0;
  bit ack_off = 1'b0;
  int req_cnt = 0;
  int wr_cnt = 0;
  int end_cnt = 0;
  int err_cnt = 0;

  logic [31:0] exp_addr_q[$];
  wr_t         exp_wr_q[$];
  evt_t        exp_evt_q[$];

  cache_refill_seq dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .blk_addr  (blk_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .dwr       (dwr),
    .dword_idx (dword_idx),
    .dwdata    (dwdata),
    .end_fill  (end_fill),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] dataOf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flagMissing(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: DUT produced an event with nothing expected", name);
  endtask

  // Memory model: acks after ack_delay waiting cycles, driven mid-cycle after the edge.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_req && !ack_off) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack   = 1'b1;
          mem_rdata = dataOf(mem_addr);
          wait_cnt  = 0;
        end else begin
          mem_ack  = 1'b0;
          wait_cnt++;
        end
      end else begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end
    end
  end

  initial begin
    logic [31:0] a;
    wr_t         w;
    evt_t        e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_req) req_cnt++;
        if (mem_req && mem_ack) begin
          if (exp_addr_q.size() == 0) flagMissing("mem_addr_unexpected");
          else begin
            a = exp_addr_q.pop_front();
            checkOutput("mem_addr", mem_addr, a);
          end
        end
        if (dwr) begin
          wr_cnt++;
          if (exp_wr_q.size() == 0) flagMissing("dwr_unexpected");
          else begin
            w = exp_wr_q.pop_front();
            checkOutput("dword_idx", dword_idx, w.idx);
            checkOutput("dwdata", dwdata, w.data);
          end
        end
        if (end_fill) begin
          end_cnt++;
          if (exp_evt_q.size() == 0) flagMissing("end_fill_unexpected");
          else begin
            e = exp_evt_q.pop_front();
            checkOutput("end_fill_kind", EVT_END, e.code);
            checkOutput("end_fill_latency", cyc - start_cyc + 1, e.lat);
          end
        end
        if (err) begin
          err_cnt++;
          if (exp_evt_q.size() == 0) flagMissing("err_unexpected");
          else begin
            e = exp_evt_q.pop_front();
            checkOutput("err_kind", EVT_ERR, e.code);
            checkOutput("err_latency", cyc - start_cyc + 1, e.lat);
          end
        end
      end
    end
  end

  task automatic applyStimulus(input logic [31:0] addr);
    @(negedge clk);
    blk_addr = addr;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start     = 1'b0;
  endtask

  task automatic expectWords(input logic [31:0] base, input int nwords);
    wr_t w;
    for (int i = 0; i < nwords; i++) begin
      exp_addr_q.push_back(base + i);
      w.idx  = 2'(i);
      w.data = dataOf(base + i);
      exp_wr_q.push_back(w);
    end
  endtask

  task automatic expectEvent(input int code, input int lat);
    evt_t e;
    e.code = code;
    e.lat  = lat;
    exp_evt_q.push_back(e);
  endtask

  task automatic clearCounts();
    req_cnt = 0;
    wr_cnt  = 0;
    end_cnt = 0;
    err_cnt = 0;
  endtask

  task automatic waitIdle(input int max_cyc, input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    checkOutput({name, "_idle"}, busy, 0);
    repeat (2) @(negedge clk);
    checkOutput({name, "_pending"}, exp_addr_q.size() + exp_wr_q.size() + exp_evt_q.size(), 0);
  endtask

  initial begin
    int n;
    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    blk_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_mem_req", mem_req, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_dwr", dwr, 0);
    checkOutput("rst_dword_idx", dword_idx, 0);
    checkOutput("rst_dwdata", dwdata, 0);
    checkOutput("rst_end_fill", end_fill, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b0;

    $display("[TB] test 1: immediate ack");
    clearCounts();
    ack_delay = 0;
    exp_addr_q.push_back(32'h0000_1234);
    exp_addr_q.push_back(32'h0000_1235);
    exp_addr_q.push_back(32'h0000_1236);
    exp_addr_q.push_back(32'h0000_1237);
    for (int i = 0; i < 4; i++) exp_wr_q.push_back('{2'(i), dataOf(32'h0000_1234 + i)});
    expectEvent(EVT_END, 9);
    applyStimulus(32'h0000_1235);
    waitIdle(40, "t1");
    checkOutput("t1_writes", wr_cnt, 4);
    checkOutput("t1_end_count", end_cnt, 1);

    $display("[TB] test 2: ack delayed 3 cycles");
    clearCounts();
    ack_delay = 3;
    expectWords(32'h0000_ABCC, 4);
    expectEvent(EVT_END, 21);
    applyStimulus(32'h0000_ABCE);
    waitIdle(60, "t2");
    checkOutput("t2_req_cycles", req_cnt, 16);
    checkOutput("t2_end_count", end_cnt, 1);

    $display("[TB] test 3: no ack, timeout");
    clearCounts();
    ack_off   = 1'b1;
    ack_delay = 0;
    expectEvent(EVT_ERR, 17);
    applyStimulus(32'h0000_0040);
    waitIdle(60, "t3");
    checkOutput("t3_req_cycles", req_cnt, 16);
    checkOutput("t3_writes", wr_cnt, 0);
    checkOutput("t3_end_count", end_cnt, 0);
    checkOutput("t3_err_count", err_cnt, 1);
    ack_off = 1'b0;

    $display("[TB] test 4: abort in word 2 request with same-cycle ack");
    clearCounts();
    expectWords(32'h0000_5550, 2);
    exp_addr_q.push_back(32'h0000_5552);
    applyStimulus(32'h0000_5550);
    @(negedge clk);
    n = 0;
    while (!(mem_req && mem_addr[1:0] == 2'd2) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t4_reach_word2", mem_req, 1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checkOutput("t4_busy_after_abort", busy, 0);
    checkOutput("t4_dwr_after_abort", dwr, 0);
    waitIdle(20, "t4");
    checkOutput("t4_writes", wr_cnt, 2);
    checkOutput("t4_end_count", end_cnt, 0);

    $display("[TB] test 5: start+abort in idle, start while busy");
    clearCounts();
    @(negedge clk);
    blk_addr = 32'h0000_7777;
    start    = 1'b1;
    abort    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    abort = 1'b0;
    checkOutput("t5_start_abort_idle", busy, 0);
    expectWords(32'h0000_3000, 4);
    expectEvent(EVT_END, 9);
    applyStimulus(32'h0000_3003);
    repeat (2) @(negedge clk);
    blk_addr = 32'h0000_9990;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle(40, "t5");
    checkOutput("t5_writes", wr_cnt, 4);
    checkOutput("t5_end_count", end_cnt, 1);

    $display("[TB] test 6: async reset mid-write");
    clearCounts();
    expectWords(32'h0000_8008, 4);
    expectEvent(EVT_END, 9);
    applyStimulus(32'h0000_8008);
    @(negedge clk);
    n = 0;
    while (!(dwr && dword_idx == 2'd1) && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("t6_reach_write1", dwr, 1);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_dwr", dwr, 0);
    checkOutput("t6_async_mem_req", mem_req, 0);
    checkOutput("t6_async_busy", busy, 0);
    exp_addr_q.delete();
    exp_wr_q.delete();
    exp_evt_q.delete();
    @(negedge clk);
    reset = 1'b0;
    clearCounts();
    expectWords(32'h0000_C000, 4);
    expectEvent(EVT_END, 9);
    applyStimulus(32'h0000_C002);
    waitIdle(40, "t6");
    checkOutput("t6_writes", wr_cnt, 4);
    checkOutput("t6_end_count", end_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
